// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32x32 multiply / divide unit with HI/LO registers
// Define MDU_DIV_EN to build the restoring divider; without it div/divu complete at once and leave hi/lo alone.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_q, neg_d;

  logic        is_signed, sign_a, sign_b;
  logic [31:0] mag_a_in, mag_b_in;
  logic [32:0] mul_sum;
  logic [63:0] prod, prod_fix;

`ifdef MDU_DIV_EN
  logic        is_div_q, is_div_d;
  logic        rem_neg_q, rem_neg_d;
  logic [32:0] div_shift;
  logic [31:0] div_diff, div_rem, div_quo;
  logic        div_borrow;
`endif

  always_comb begin
    is_signed = ~op[0];
    sign_a    = is_signed & a[31];
    sign_b    = is_signed & b[31];
    mag_a_in  = sign_a ? (32'd0 - a) : a;
    mag_b_in  = sign_b ? (32'd0 - b) : b;

    // acc:sh is the running 64-bit product; multiplier bits leave sh from the bottom
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mag_b_q} : 33'd0);
    prod     = {mul_sum, sh_q[31:1]};
    prod_fix = neg_q ? (64'd0 - prod) : prod;

`ifdef MDU_DIV_EN
    // acc holds the partial remainder, sh shifts dividend bits out and quotient bits in
    div_shift  = {acc_q, sh_q[31]};
    div_borrow = div_shift < {1'b0, mag_b_q};
    div_diff   = div_shift[31:0] - mag_b_q;
    div_rem    = div_borrow ? div_shift[31:0] : div_diff;
    div_quo    = {sh_q[30:0], ~div_borrow};
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    rem_neg_d = rem_neg_q;
`endif

    if (state_q != RUN) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MDU_DIV_EN
          state_d   = RUN;
          is_div_d  = op[1];
          rem_neg_d = sign_a;
          // divide by zero must leave an all-ones quotient, so never negate it
          neg_d     = (sign_a ^ sign_b) & ~(op[1] && (b == 32'd0));
`else
          state_d   = op[1] ? DONE : RUN;
          neg_d     = sign_a ^ sign_b;
`endif
          cnt_d   = 5'd0;
          acc_d   = 32'd0;
          sh_d    = mag_a_in;
          mag_b_d = mag_b_in;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          acc_d = div_rem;
          sh_d  = div_quo;
        end else begin
          acc_d = mul_sum[32:1];
          sh_d  = {mul_sum[0], sh_q[31:1]};
        end
`else
        acc_d = mul_sum[32:1];
        sh_d  = {mul_sum[0], sh_q[31:1]};
`endif
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          cnt_d   = 5'd0;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            hi_d = rem_neg_q ? (32'd0 - div_rem) : div_rem;
            lo_d = neg_q ? (32'd0 - div_quo) : div_quo;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
`else
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 32'd0;
      sh_q    <= 32'd0;
      mag_b_q <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit (div checks follow MDU_DIV_EN)
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_hl(input logic [31:0] hv, input logic [31:0] lv);
    @(negedge clk);
    hi_we = 1'b1;
    wdata = hv;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = lv;
    @(negedge clk);
    lo_we = 1'b0;
    check("wr.hi", hi, hv);
    check("wr.lo", lo, lv);
  endtask

  // lat = edges from the accepting edge to the edge that raises done
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input bit disturb, input bit wr);
    int          busy_bad;
    int          extra_done;
    logic [31:0] hi_prev;
    busy_bad   = 0;
    extra_done = 0;
    hi_prev    = hi;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (wr) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h55AA55AA;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int j = 0; j < lat; j++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      if (disturb) begin
        if (j == 4) begin
          start = 1'b1;
          a     = 32'h11111111;
          b     = 32'h00000002;
        end
        if (j == 5) start = 1'b0;
        if (j == 9) begin
          hi_we = 1'b1;
          wdata = 32'hBADBAD00;
        end
        if (j == 10) hi_we = 1'b0;
        if (j == 11) check($sformatf("%s.hi_hold", tag), hi, hi_prev);
      end
      @(posedge clk);
      #1;
    end
    if (lat > 0) check($sformatf("%s.busy_window", tag), busy_bad, 0);
    check($sformatf("%s.done", tag), done, 1'b1);
    check($sformatf("%s.busy_at_done", tag), busy, 1'b0);
    check($sformatf("%s.hi", tag), hi, eh);
    check($sformatf("%s.lo", tag), lo, el);
    @(posedge clk);
    #1;
    check($sformatf("%s.done_pulse", tag), done, 1'b0);
    if (disturb) begin
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done) extra_done++;
      end
      check($sformatf("%s.no_queue", tag), extra_done, 0);
      check($sformatf("%s.hi_final", tag), hi, eh);
    end
  endtask

  initial begin
    int rst_done;
    rst_done = 0;
    #12;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.hi", hi, 32'd0);
    check("rst.lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32, 0, 0);
    do_op("mult_m7x3",  2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 32, 0, 0);
    do_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32, 0, 0);
    do_op("multu_x16",  2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 32, 0, 0);
    do_op("mult_5xm1",  2'b00, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 32, 0, 0);
    do_op("mult_ign",   2'b00, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 32, 1, 0);
    do_op("multu_wr",   2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 32, 0, 1);

    write_hl(32'hDEADBEEF, 32'hCAFEF00D);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'hFFFFFFF9;
    b     = 32'h00000003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid.busy", busy, 1'b0);
    check("rstmid.done", done, 1'b0);
    check("rstmid.hi", hi, 32'd0);
    check("rstmid.lo", lo, 32'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) rst_done++;
    end
    check("rstmid.no_done", rst_done, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    do_op("post_rst",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32, 0, 0);

`ifdef MDU_DIV_EN
    do_op("div_m7d2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, 0, 0);
    do_op("div_7dm2",   2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32, 0, 0);
    do_op("divu_100d0", 2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 32, 0, 0);
    do_op("div_m7d0",   2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 32, 0, 0);
    do_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32, 0, 0);
    do_op("divu_100d7", 2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 32, 0, 0);
`else
    write_hl(32'h12345678, 32'h9ABCDEF0);
    do_op("div_off",    2'b10, 32'h00000007, 32'h00000002, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0);
    do_op("divu_off",   2'b11, 32'h00000064, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0);
    do_op("div_off_wr", 2'b10, 32'h00000001, 32'h00000001, 32'h55AA55AA, 32'h55AA55AA, 0, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The module SHALL provide exactly one clock and reset, asynchronous and active-low, as the ports below.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new operation; sampled only while busy=0.
REQ-005 op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a  input  32  operand A (multiplicand or dividend).
REQ-007 b  input  32  operand B (multiplier or divisor).
REQ-008 hi_we  input  1  mthi strobe; loads wdata into hi.
REQ-009 lo_we  input  1  mtlo strobe; loads wdata into lo.
REQ-010 wdata  input  32  data for hi_we/lo_we.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 hi  output  32  HI register (product[63:32] or remainder).
REQ-014 lo  output  32  LO register (product[31:0] or quotient).

Function
REQ-015 States: IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE with start=1 at edge T: latch op, operand magnitudes and result signs; enter RUN; busy=1 from T+1.
REQ-017 RUN: exactly 32 iterations, one per cycle (radix-2 shift-add multiply, restoring divide); iteration counter 0..31, then DONE.
REQ-018 Entry into DONE: hi/lo updated with the final sign-corrected result; done=1 for exactly that one cycle; busy=0 in DONE; then IDLE.
REQ-019 Latency: start at edge T -> done=1 and new hi/lo visible in cycle T+33.
REQ-020 busy=1 only in RUN; start while busy SHALL be ignored (no queuing).
REQ-021 mult/div: signed two's-complement; multu/divu: unsigned.
REQ-022 Signed division: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-023 Divide by zero: normal latency, lo=32'hFFFFFFFF, hi=a, no error flag.
REQ-024 div 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-025 hi_we/lo_we outside RUN: write takes effect at the next edge; during RUN they SHALL be ignored.
REQ-026 Same edge as accepted start: hi_we/lo_we write applies; the later operation result overwrites it.
REQ-027 hi/lo SHALL otherwise hold their values; operand inputs may change freely after start is accepted.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, independent of clk.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse and no partial hi/lo update.
REQ-030 Reset release SHALL be synchronized outside this block; the first start is accepted on the first edge after release.

Configuration
REQ-031 Macro MDU_DIV_EN defined: div/divu implemented as specified above.
REQ-032 Macro MDU_DIV_EN undefined: no divider logic; div/divu accepted, done pulses in cycle T+1 (busy never asserted), hi/lo unchanged; multiply behaviour unaffected.

Verification
REQ-033 multu a=32'hFFFFFFFF b=32'hFFFFFFFF -> done at T+33, hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-034 mult a=-7 (32'hFFFFFFF9) b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high cycles T+1..T+32.
REQ-035 div a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; divu a=100 b=0 -> lo=32'hFFFFFFFF, hi=100.
REQ-036 start pulsed at T+5 during RUN with different operands -> ignored, single done at T+33 with original result; hi_we at T+10 ignored.
REQ-037 rst_n low at T+15 mid-multiply -> busy=0, hi=lo=0 immediately, no done; new start after release completes normally.
REQ-038 MDU_DIV_EN undefined, hi preloaded 32'h12345678 via hi_we, div issued -> done at T+1, hi/lo unchanged.
